// File: rtl/ntt_sdf_sched_pkg.sv
// Shared types and helpers for the SDF NTT frame scheduler.
package ntt_sdf_sched_pkg;
  localparam int DEF_LOGQ = 64;
  localparam int DEF_LOGN = 10;
  // Wide enough for any modulus width the chain is built with.
  localparam int CFG_QW   = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic              intt;
    logic              gs;
    logic [CFG_QW-1:0] q;
  } cfg_t;

  function automatic logic cfg_eq(input cfg_t a, input cfg_t b);
    return a == b;
  endfunction
endpackage

// File: rtl/ntt_sdf_sched_if.sv
// Job, sample, SDF-chain and output signals of the NTT frame scheduler.
interface ntt_sdf_sched_if #(parameter int LOGQ = 64);
  logic            job_valid;
  logic            job_ready;
  logic            job_intt;
  logic            job_gs;
  logic [LOGQ-1:0] job_q;
  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] in_data;
  logic            pipe_start;
  logic [LOGQ-1:0] pipe_data;
  logic            pipe_intt;
  logic            pipe_btf_gs;
  logic [LOGQ-1:0] pipe_q;
  logic            pipe_finish;
  logic [LOGQ-1:0] pipe_dout;
  logic            out_valid;
  logic [LOGQ-1:0] out_data;
  logic            out_last;
  logic            busy;
  logic            err_underrun;
  logic            err_overrun;

  modport master (
    input  job_valid, job_intt, job_gs, job_q, in_valid, in_data,
           pipe_finish, pipe_dout,
    output job_ready, in_ready, pipe_start, pipe_data, pipe_intt,
           pipe_btf_gs, pipe_q, out_valid, out_data, out_last, busy,
           err_underrun, err_overrun
  );

  modport slave (
    output job_valid, job_intt, job_gs, job_q, in_valid, in_data,
           pipe_finish, pipe_dout,
    input  job_ready, in_ready, pipe_start, pipe_data, pipe_intt,
           pipe_btf_gs, pipe_q, out_valid, out_data, out_last, busy,
           err_underrun, err_overrun
  );
endinterface

// File: rtl/ntt_sdf_sched.sv
// Frame scheduler for the SDF NTT chain: feeds frames, holds config stable,
// drains the always-advancing pipeline before any config change.
module ntt_sdf_sched
  import ntt_sdf_sched_pkg::*;
#(
  parameter int LOGQ   = DEF_LOGQ,
  parameter int LOGN   = DEF_LOGN,
  parameter int OCNT_W = LOGN + 2
)(
  input  logic             clk,
  input  logic             rst,
  ntt_sdf_sched_if.master  bus
);

  state_e            r_state, w_state_nxt;
  logic [LOGN-1:0]   r_scnt, r_ocnt;
  logic [OCNT_W-1:0] r_infl, w_infl_nxt;

  logic              r_p_intt, r_p_gs;
  logic [LOGQ-1:0]   r_p_q;
  logic              r_intt, r_gs;
  logic [LOGQ-1:0]   r_q;

  logic              r_start;
  logic [LOGQ-1:0]   r_pdata;
  logic              r_ovld;
  logic [LOGQ-1:0]   r_odata;
  logic              r_busy, r_err_ur, r_err_ov;

  logic              w_job_ready, w_in_ready, w_in_hs, w_gap;
  logic              w_apply_job, w_apply_pend, w_can_go;
  cfg_t              w_cfg_job, w_cfg_cur;

  always_comb begin
    w_cfg_job      = '0;
    w_cfg_job.intt = bus.job_intt;
    w_cfg_job.gs   = bus.job_gs;
    w_cfg_job.q    = CFG_QW'(bus.job_q);
    w_cfg_cur      = '0;
    w_cfg_cur.intt = r_intt;
    w_cfg_cur.gs   = r_gs;
    w_cfg_cur.q    = CFG_QW'(r_q);
  end

  // A sample registered into pipe_start is not yet counted, so it also blocks
  // an immediate config switch.
  assign w_can_go = ((r_infl == '0) && !r_start) || cfg_eq(w_cfg_job, w_cfg_cur);

  // In-flight occupancy after this cycle's start/finish.
  always_comb begin
    w_infl_nxt = r_infl;
    if (r_start && !bus.pipe_finish) begin
      if (r_infl != '1) w_infl_nxt = r_infl + OCNT_W'(1);
    end else if (!r_start && bus.pipe_finish) begin
      if (r_infl != '0) w_infl_nxt = r_infl - OCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_job_ready  = 1'b0;
    w_in_ready   = 1'b0;
    w_apply_job  = 1'b0;
    w_apply_pend = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_job_ready = 1'b1;
        if (bus.job_valid) begin
          if (w_can_go) begin
            w_apply_job = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_infl_nxt == '0) begin
          w_apply_pend = 1'b1;
          w_state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (&r_scnt)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_in_hs = bus.in_valid & w_in_ready;
  assign w_gap   = (r_state == ST_LOAD) & ~bus.in_valid & (r_scnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_intt <= 1'b0;
      r_p_gs   <= 1'b0;
      r_p_q    <= '0;
      r_intt   <= 1'b0;
      r_gs     <= 1'b0;
      r_q      <= '0;
      r_scnt   <= '0;
      r_start  <= 1'b0;
      r_pdata  <= '0;
      r_infl   <= '0;
      r_ovld   <= 1'b0;
      r_odata  <= '0;
      r_ocnt   <= '0;
      r_busy   <= 1'b0;
      r_err_ur <= 1'b0;
      r_err_ov <= 1'b0;
    end else begin
      if (w_job_ready && bus.job_valid) begin
        r_p_intt <= bus.job_intt;
        r_p_gs   <= bus.job_gs;
        r_p_q    <= bus.job_q;
      end
      if (w_apply_job) begin
        r_intt <= bus.job_intt;
        r_gs   <= bus.job_gs;
        r_q    <= bus.job_q;
      end else if (w_apply_pend) begin
        r_intt <= r_p_intt;
        r_gs   <= r_p_gs;
        r_q    <= r_p_q;
      end

      // scnt wraps to 0 naturally on the Nth sample.
      if (w_in_hs) begin
        r_scnt  <= r_scnt + LOGN'(1);
        r_pdata <= bus.in_data;
      end
      r_start <= w_in_hs;
      r_infl  <= w_infl_nxt;

      r_ovld <= bus.pipe_finish;
      if (bus.pipe_finish) r_odata <= bus.pipe_dout;
      if (r_ovld) r_ocnt <= r_ocnt + LOGN'(1);

      r_busy <= (r_state != ST_IDLE) || (r_infl != '0);
      if (w_gap) r_err_ur <= 1'b1;
      if (bus.pipe_finish && (r_infl == '0)) r_err_ov <= 1'b1;
    end
  end

  assign bus.job_ready    = w_job_ready;
  assign bus.in_ready     = w_in_ready;
  assign bus.pipe_start   = r_start;
  assign bus.pipe_data    = r_pdata;
  assign bus.pipe_intt    = r_intt;
  assign bus.pipe_btf_gs  = r_gs;
  assign bus.pipe_q       = r_q;
  assign bus.out_valid    = r_ovld;
  assign bus.out_data     = r_odata;
  assign bus.out_last     = r_ovld & (&r_ocnt);
  assign bus.busy         = r_busy;
  assign bus.err_underrun = r_err_ur;
  assign bus.err_overrun  = r_err_ov;

endmodule
